// File: rtl/pci_txn_queue_if.sv
// pci_txn_queue_if: host push port plus PCI device/bus signals of pci_txn_queue.
// master = host and bus side (drives pushes and bus lines), slave = the queue itself.
interface pci_txn_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [31:0]   push_addr;
    logic [31:0]   push_data;
    logic [3:0]    push_be;
    logic          push_rw;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    logic          grant;
    logic          iframe;
    logic          iready;
    logic          tready;
    logic          devsel;
    logic [31:0]   AD;

    logic          force_req;
    logic          rw;
    logic [31:0]   contactAddress;
    logic [31:0]   data;
    logic [3:0]    BE;
    logic          done;
    logic          abort;
    logic          rd_valid;
    logic [31:0]   rd_data;

    modport master (
        output push, push_addr, push_data, push_be, push_rw,
        output grant, iframe, iready, tready, devsel, AD,
        input  full, empty, count, overflow,
        input  force_req, rw, contactAddress, data, BE,
        input  done, abort, rd_valid, rd_data
    );

    modport slave (
        input  push, push_addr, push_data, push_be, push_rw,
        input  grant, iframe, iready, tready, devsel, AD,
        output full, empty, count, overflow,
        output force_req, rw, contactAddress, data, BE,
        output done, abort, rd_valid, rd_data
    );
endinterface

// File: rtl/pci_txn_queue.sv
// pci_txn_queue: FIFO of single-word PCI transactions presented one at a time to a device.
// PCI_TXN_QUEUE_RETRY_EN: retry DEVSEL timeouts up to MAX_RETRY times before aborting.
module pci_txn_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned DEVSEL_TIMEOUT = 5,
    parameter int unsigned MAX_RETRY      = 2
) (
    input logic            clk,
    input logic            rst,
    pci_txn_queue_if.slave q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(DEVSEL_TIMEOUT + 1);

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        ABORT = 3'd4,
        TURN  = 3'd5
    } state_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          force_req;
    logic          head_rw;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic [3:0]    head_be;
    logic          done;
    logic          abort;
    logic          rd_valid;
    logic [31:0]   rd_data;

    logic          grant_c;
    logic          iready_c;
    logic          tready_c;
    logic          devsel_c;
    logic          tmo_hit_c;
    logic          last_try_c;
    logic          complete_c;
    logic          timeout_pop_c;
    logic          pop_c;
    logic          push_acc_c;
    logic [CW-1:0] count_nxt_c;
    logic          unused_iframe;

    // Active-low bus decode; anything other than a clean 0 counts as deasserted.
    always_comb begin
        grant_c  = 1'b0;
        iready_c = 1'b0;
        tready_c = 1'b0;
        devsel_c = 1'b0;
        if (q.grant == 1'b0)  grant_c  = 1'b1;
        if (q.iready == 1'b0) iready_c = 1'b1;
        if (q.tready == 1'b0) tready_c = 1'b1;
        if (q.devsel == 1'b0) devsel_c = 1'b1;
    end

    assign unused_iframe = q.iframe;

`ifdef PCI_TXN_QUEUE_RETRY_EN
    localparam int unsigned RTW = $clog2(MAX_RETRY + 2);
    logic [RTW-1:0] retry_cnt;
    logic           retry_turn;
    assign last_try_c = (retry_cnt == RTW'(MAX_RETRY));
`else
    logic [31:0]    unused_max_retry;
    assign last_try_c       = 1'b1;
    assign unused_max_retry = 32'(MAX_RETRY);
`endif

    assign tmo_hit_c     = ((tmo_cnt + TW'(1)) == TW'(DEVSEL_TIMEOUT));
    assign complete_c    = (state == DATA) && grant_c && iready_c && tready_c && devsel_c;
    assign timeout_pop_c = (state == ADDR) && grant_c && !devsel_c && tmo_hit_c && last_try_c;
    assign pop_c         = complete_c || timeout_pop_c;
    assign push_acc_c    = q.push && !full;
    assign count_nxt_c   = count + CW'(push_acc_c) - CW'(pop_c);

    // Pointer/occupancy tracking; a push while full is dropped even if a pop coincides.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_acc_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)      rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nxt_c;
            full     <= (count_nxt_c == CW'(DEPTH));
            empty    <= (count_nxt_c == '0);
            overflow <= q.push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc_c) mem[wr_ptr] <= {q.push_rw, q.push_addr, q.push_data, q.push_be};
    end

    // Transaction sequencer; reads report through rd_valid, writes through done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            force_req <= 1'b0;
            head_rw   <= 1'b0;
            head_addr <= '0;
            head_data <= '0;
            head_be   <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
`ifdef PCI_TXN_QUEUE_RETRY_EN
            retry_cnt  <= '0;
            retry_turn <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            abort    <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        head_rw   <= mem[rd_ptr].rw;
                        head_addr <= mem[rd_ptr].addr;
                        head_data <= mem[rd_ptr].data;
                        head_be   <= mem[rd_ptr].be;
                        force_req <= 1'b1;
                        state     <= REQ;
`ifdef PCI_TXN_QUEUE_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (grant_c) begin
                        tmo_cnt <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (!grant_c) begin
                        state <= REQ;
                    end else if (devsel_c) begin
                        state <= DATA;
                    end else if (tmo_hit_c) begin
                        if (last_try_c) begin
                            abort <= 1'b1;
                            state <= ABORT;
                        end
`ifdef PCI_TXN_QUEUE_RETRY_EN
                        else begin
                            retry_cnt  <= retry_cnt + RTW'(1);
                            retry_turn <= 1'b1;
                            force_req  <= 1'b0;
                            state      <= TURN;
                        end
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (!grant_c) begin
                        state <= REQ;
                    end else if (complete_c) begin
                        if (head_rw) begin
                            done <= 1'b1;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_data  <= q.AD;
                        end
                        force_req <= 1'b0;
                        state     <= TURN;
                    end
                end
                ABORT: begin
                    force_req <= 1'b0;
                    state     <= TURN;
                end
                TURN: begin
`ifdef PCI_TXN_QUEUE_RETRY_EN
                    if (retry_turn) begin
                        retry_turn <= 1'b0;
                        force_req  <= 1'b1;
                        state      <= REQ;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    force_req <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign q.full           = full;
    assign q.empty          = empty;
    assign q.count          = count;
    assign q.overflow       = overflow;
    assign q.force_req      = force_req;
    assign q.rw             = head_rw;
    assign q.contactAddress = head_addr;
    assign q.data           = head_data;
    assign q.BE             = head_be;
    assign q.done           = done;
    assign q.abort          = abort;
    assign q.rd_valid       = rd_valid;
    assign q.rd_data        = rd_data;
endmodule

// File: tb/tb_pci_txn_queue.sv
// tb_pci_txn_queue: randomized bench for pci_txn_queue against a transaction-level queue model.
// Honors PCI_TXN_QUEUE_RETRY_EN when the design is built with it.
module tb_pci_txn_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 5;
    localparam int unsigned RETRY = 2;
`ifdef PCI_TXN_QUEUE_RETRY_EN
    localparam int ABORT_LAT = (RETRY + 1) * TMO + 2 * RETRY;
    localparam int RE_REQS   = RETRY;
`else
    localparam int ABORT_LAT = TMO;
    localparam int RE_REQS   = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pci_txn_queue_if #(.DEPTH(DEPTH)) bus ();

    pci_txn_queue #(
        .DEPTH(DEPTH),
        .DEVSEL_TIMEOUT(TMO),
        .MAX_RETRY(RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q(bus)
    );

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    txn_t mq[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   push_pct = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model for the edge just taken, check occupancy, drive the next push.
    task automatic tick();
        int   pre;
        bit   pushed;
        bit   in_rst;
        txn_t t;
        pre    = mq.size();
        pushed = bus.push;
        in_rst = rst;
        t      = '{bus.push_rw, bus.push_addr, bus.push_data, bus.push_be};
        @(posedge clk);
        #1;
        if (in_rst) begin
            mq.delete();
        end else begin
            if (bus.done || bus.abort || bus.rd_valid) begin
                if (mq.size() == 0) check("pop_on_empty_model", 32'(mq.size()), 32'd1);
                else void'(mq.pop_front());
            end
            if (pushed && pre < int'(DEPTH)) mq.push_back(t);
        end
        check("overflow", 32'(bus.overflow), 32'(!in_rst && pushed && pre == int'(DEPTH)));
        check("count", 32'(bus.count), 32'(mq.size()));
        check("full", 32'(bus.full), 32'(mq.size() == int'(DEPTH)));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        if (push_pct > 0 && int'($urandom_range(99)) < push_pct) begin
            bus.push      = 1'b1;
            bus.push_rw   = 1'($urandom_range(1));
            bus.push_addr = $urandom();
            bus.push_data = $urandom();
            bus.push_be   = 4'($urandom_range(15));
        end else begin
            bus.push = 1'b0;
        end
    endtask

    task automatic do_push(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        bus.push      = 1'b1;
        bus.push_rw   = rw;
        bus.push_addr = addr;
        bus.push_data = data;
        bus.push_be   = be;
        tick();
    endtask

    task automatic release_bus();
        bus.grant  = 1'b1;
        bus.devsel = 1'b1;
        bus.tready = 1'b1;
        bus.iready = 1'b1;
    endtask

    // Acts as arbiter and target for the next queued transaction and checks its outcome.
    task automatic serve(input bit respond, input bit preempt, input logic [31:0] ad);
        txn_t h;
        int   n;
        int   lat;
        int   rises;
        bit   prev;
        bit   seen;
        n = 0;
        while (bus.force_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 32'(bus.force_req), 32'd1);
        if (bus.force_req !== 1'b1) return;
        check("model_has_head", 32'(mq.size() > 0), 32'd1);
        if (mq.size() == 0) return;
        h = mq[0];
        check("head_rw", 32'(bus.rw), 32'(h.rw));
        check("head_addr", bus.contactAddress, h.addr);
        check("head_data", bus.data, h.data);
        check("head_be", 32'(bus.BE), 32'(h.be));
        bus.grant = 1'b0;
        tick();
        if (respond) begin
            bus.devsel = 1'b0;
            bus.tready = 1'b0;
            bus.iready = 1'b0;
            bus.AD     = ad;
        end
        if (preempt) begin
            tick();
            bus.grant = 1'b1;
            tick();
            check("preempt_req", 32'(bus.force_req), 32'd1);
            check("preempt_addr", bus.contactAddress, h.addr);
            check("preempt_quiet", 32'({bus.done, bus.abort, bus.rd_valid}), 32'd0);
            tick();
            check("preempt_hold", 32'(bus.force_req), 32'd1);
            bus.grant = 1'b0;
            tick();
        end
        lat   = 0;
        rises = 0;
        prev  = 1'b1;
        seen  = 1'b0;
        while (!seen && lat < 60) begin
            tick();
            lat++;
            if (bus.force_req && !prev) rises++;
            prev = bus.force_req;
            seen = bus.done || bus.abort || bus.rd_valid;
        end
        check("event_seen", 32'(seen), 32'd1);
        if (respond) begin
            check("done", 32'(bus.done), 32'(h.rw));
            check("rd_valid", 32'(bus.rd_valid), 32'(!h.rw));
            check("no_abort", 32'(bus.abort), 32'd0);
            check("cpl_latency", 32'(lat), 32'd2);
            if (!h.rw) check("rd_data", bus.rd_data, ad);
        end else begin
            check("abort", 32'(bus.abort), 32'd1);
            check("abort_no_cpl", 32'({bus.done, bus.rd_valid}), 32'd0);
            check("abort_latency", 32'(lat), 32'(ABORT_LAT));
            check("re_requests", 32'(rises), 32'(RE_REQS));
        end
        release_bus();
        tick();
        check("pulse_single", 32'({bus.done, bus.abort, bus.rd_valid}), 32'd0);
        check("turn_req_low", 32'(bus.force_req), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.push_data = '0;
        bus.push_be   = '0;
        bus.push_rw   = 1'b0;
        bus.iframe    = 1'b1;
        bus.AD        = '0;
        release_bus();
        rst = 1'b1;
        tick();
        tick();
        check("rst_force_req", 32'(bus.force_req), 32'd0);
        check("rst_rw", 32'(bus.rw), 32'd0);
        check("rst_addr", bus.contactAddress, 32'd0);
        check("rst_data", bus.data, 32'd0);
        check("rst_be", 32'(bus.BE), 32'd0);
        check("rst_pulses", 32'({bus.done, bus.abort, bus.rd_valid}), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        rst = 1'b0;
        tick();

        // Single write: force_req two edges after the push edge.
        do_push(1'b1, 32'd20, 32'h7667_7667, 4'b1000);
        check("req_lat_edge1", 32'(bus.force_req), 32'd0);
        tick();
        check("req_lat_edge2", 32'(bus.force_req), 32'd1);
        serve(1'b1, 1'b0, 32'hDEAD_BEEF);

        // Single read returns the target word.
        do_push(1'b0, 32'd10, 32'h0, 4'hF);
        serve(1'b1, 1'b0, 32'h0F0F_0F0F);
        check("read_word", bus.rd_data, 32'h0F0F_0F0F);

        // Fill with grant held off, fifth push overflows, then drain in order.
        for (int i = 0; i < 5; i++) begin
            do_push(1'(i & 1), 32'h100 + 32'(i) * 32'd4, 32'hA000_0000 + 32'(i), 4'hF);
            if (i == 3) begin
                check("fill_full", 32'(bus.full), 32'd1);
                check("fill_count", 32'(bus.count), 32'd4);
            end
            if (i == 4) begin
                check("fill_overflow", 32'(bus.overflow), 32'd1);
                check("fill_count_ovf", 32'(bus.count), 32'd4);
            end
        end
        for (int i = 0; i < 4; i++) serve(1'b1, 1'b0, $urandom());
        check("drained", 32'(bus.count), 32'd0);

        // Master abort: devsel never asserted.
        do_push(1'b1, 32'h40, 32'h1234_5678, 4'h3);
        serve(1'b0, 1'b0, 32'h0);
        check("abort_popped", 32'(bus.count), 32'd0);

        // Preemption mid-DATA, then reset flushes a two-entry queue.
        do_push(1'b1, 32'h88, 32'h5555_AAAA, 4'hC);
        tick();
        check("pre_req", 32'(bus.force_req), 32'd1);
        bus.grant = 1'b0;
        tick();
        bus.devsel = 1'b0;
        bus.tready = 1'b0;
        bus.iready = 1'b0;
        bus.push      = 1'b1;
        bus.push_rw   = 1'b0;
        bus.push_addr = 32'h99;
        bus.push_data = 32'h0;
        bus.push_be   = 4'hF;
        tick();
        bus.grant = 1'b1;
        tick();
        check("preempt_back_req", 32'(bus.force_req), 32'd1);
        check("preempt_same_addr", bus.contactAddress, 32'h88);
        check("preempt_no_done", 32'(bus.done), 32'd0);
        check("preempt_count", 32'(bus.count), 32'd2);
        rst = 1'b1;
        tick();
        check("rst_mid_req", 32'(bus.force_req), 32'd0);
        check("rst_mid_empty", 32'(bus.empty), 32'd1);
        rst = 1'b0;
        release_bus();
        tick();
        check("rst_mid_idle", 32'(bus.force_req), 32'd0);

        // Randomized traffic with concurrent pushes, aborts and preemptions.
        push_pct = 40;
        for (int i = 0; i < 80; i++) begin
            bit resp;
            bit pre;
            if (mq.size() == 0) do_push(1'($urandom_range(1)), $urandom(), $urandom(), 4'($urandom_range(15)));
            repeat ($urandom_range(0, 3)) tick();
            resp = ($urandom_range(99) < 80);
            pre  = resp && ($urandom_range(99) < 25);
            serve(resp, pre, $urandom());
        end
        push_pct = 0;
        for (int i = 0; i < 8 && mq.size() > 0; i++) serve(1'b1, 1'b0, $urandom());
        check("final_count", 32'(bus.count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
